fetch_stage: RTL

Instruction-fetch stage of the 5-stage pipelined RISC-V core. It produces the IF/ID pipeline register that the decode stage consumes (Ins_D, PC_D, PC_4D). It honours decode's load-use stall (PC_Write, IF_ID_Write) and execute's branch flush (PCSrc_E with target).
- Talks to instruction memory over a request/response handshake with variable latency and at most one outstanding request.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/fetch_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Types and constants shared by the pipeline stages of the 5-stage RISC-V
//   core.
//   - NOP_INSTR     : canonical NOP (addi x0, x0, 0), loaded into pipeline
//                     registers as a bubble
//   - fetch_state_t : fetch-stage handshake state
//   - if_id_t       : contents of the IF/ID pipeline register
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,   // ready to issue a request at PC_F
      WAIT  = 2'd1,   // one request outstanding
      HOLD  = 2'd2    // response captured, decode is stalled
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] ins;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic            valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{ins: NOP_INSTR, pc: '0, pc4: '0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Fetches from instruction memory over a
//   request/response handshake (variable latency, at most one outstanding
//   request) and produces the IF/ID pipeline register for decode.
//
// Ports
//   clk, rst              core clock, synchronous active-high reset
//   PC_Write, IF_ID_Write load-use stall from decode (0 = hold)
//   PCSrc_E, PC_Target_E  redirect from execute; flush has top priority
//   imem_req, imem_addr   request to instruction memory (word aligned)
//   imem_ready            memory accepts the request this cycle
//   imem_rvalid/rdata     response from instruction memory
//   Ins_D, PC_D, PC_4D    IF/ID instruction, PC and PC+4
//   Valid_D               IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_stage
   import riscv_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DAT_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  PC_Write,
   input  logic                  IF_ID_Write,
   input  logic                  PCSrc_E,
   input  logic [ADDR_WIDTH-1:0] PC_Target_E,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic                  imem_rvalid,
   input  logic [DAT_WIDTH-1:0]  imem_rdata,
   output logic [DAT_WIDTH-1:0]  Ins_D,
   output logic [ADDR_WIDTH-1:0] PC_D,
   output logic [ADDR_WIDTH-1:0] PC_4D,
   output logic                  Valid_D
);

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  kill_q, kill_d;   // outstanding response must be dropped
   if_id_t                hold_q, hold_d;   // response parked while decode stalls
   if_id_t                if_id_q, if_id_d;

   logic                  advance;
   logic                  flush;
   logic [ADDR_WIDTH-1:0] pc_plus4;
   logic [ADDR_WIDTH-1:0] target;
   if_id_t                fetched;
   logic                  deliver;
   if_id_t                deliver_word;

   assign advance  = PC_Write & IF_ID_Write;
   assign flush    = PCSrc_E;
   assign pc_plus4 = pc_q + ADDR_WIDTH'(4);   // wraps modulo 2^ADDR_WIDTH
   assign target   = PC_Target_E & ALIGN_MASK;

   // In WAIT, pc_q is the address of the outstanding request, so the
   // response is tagged with it directly.
   assign fetched = '{ins:   XLEN'(imem_rdata),
                      pc:    XLEN'(pc_q),
                      pc4:   XLEN'(pc_plus4),
                      valid: 1'b1};

   // Next-state, memory request and IF/ID delivery.
   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      kill_d       = kill_q;
      hold_d       = hold_q;
      imem_req     = 1'b0;
      imem_addr    = pc_q;
      deliver      = 1'b0;
      deliver_word = hold_q;

      unique case (state_q)
         FETCH: begin
            if (flush) begin
               pc_d = target;
            end else begin
               imem_req = 1'b1;
               if (imem_ready) state_d = WAIT;
            end
         end

         WAIT: begin
            if (imem_rvalid) begin
               if (kill_q || flush) begin
                  // Stale or redirected response: drop it and refetch.
                  kill_d  = 1'b0;
                  state_d = FETCH;
                  if (flush) pc_d = target;
               end else if (advance) begin
                  deliver      = 1'b1;
                  deliver_word = fetched;
                  pc_d         = pc_plus4;
                  // Back-to-back request keeps throughput at one per cycle.
                  imem_req     = 1'b1;
                  imem_addr    = pc_plus4;
                  state_d      = imem_ready ? WAIT : FETCH;
               end else begin
                  hold_d  = fetched;
                  state_d = HOLD;
               end
            end else if (flush) begin
               // Cannot cancel an accepted request; mark its response dead.
               kill_d = 1'b1;
               pc_d   = target;
            end
         end

         HOLD: begin
            if (flush) begin
               hold_d.valid = 1'b0;
               pc_d         = target;
               state_d      = FETCH;
            end else if (advance) begin
               deliver      = 1'b1;
               deliver_word = hold_q;
               hold_d.valid = 1'b0;
               pc_d         = pc_plus4;
               state_d      = FETCH;
            end
         end

         default: state_d = FETCH;
      endcase

      if (rst) imem_req = 1'b0;
   end

   // IF/ID update: flush > stall > delivery > bubble.
   always_comb begin
      if (flush)             if_id_d = IF_ID_BUBBLE;
      else if (!IF_ID_Write) if_id_d = if_id_q;
      else if (deliver)      if_id_d = deliver_word;
      else                   if_id_d = IF_ID_BUBBLE;
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= PC_INIT;
         kill_q  <= 1'b0;
         // NOTE: the hold buffer is a single register, not a memory array,
         // so resetting it is cheap and keeps its contents deterministic.
         hold_q  <= IF_ID_BUBBLE;
         if_id_q <= IF_ID_BUBBLE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         hold_q  <= hold_d;
         if_id_q <= if_id_d;
      end
   end

   assign Ins_D   = if_id_q.ins[DAT_WIDTH-1:0];
   assign PC_D    = if_id_q.pc[ADDR_WIDTH-1:0];
   assign PC_4D   = if_id_q.pc4[ADDR_WIDTH-1:0];
   assign Valid_D = if_id_q.valid;

endmodule
